// File: rtl/store_unit_rv32i_pkg.sv
// Shared definitions for the RV32I store unit: store width encodings, the
// controller state type and the base byte-mask lookup.
package rv32i_store_pkg;

    localparam logic [2:0] W_BYTE = 3'd0;
    localparam logic [2:0] W_HALF = 3'd1;
    localparam logic [2:0] W_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Unshifted byte enables for a store width; all-zero marks an illegal width.
    function automatic logic [3:0] base_mask(input logic [2:0] width_type);
        case (width_type)
            W_BYTE:  base_mask = 4'b0001;
            W_HALF:  base_mask = 4'b0011;
            W_WORD:  base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_unit_rv32i_if.sv
// Request, write-beat and completion signals of the store unit.
// slave  : the store unit itself.
// master : its environment (memory stage issuing requests plus the data memory).
interface store_unit_rv32i_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_width_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              done_valid;
    logic              done_err;
    logic              busy;

    modport slave (
        input  req_valid, req_width_type, req_addr, req_data, mem_wready,
        output req_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
               done_valid, done_err, busy
    );

    modport master (
        output req_valid, req_width_type, req_addr, req_data, mem_wready,
        input  req_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
               done_valid, done_err, busy
    );
endinterface

// File: rtl/store_unit_rv32i_aligner.sv
// Combinational lane alignment: places right-justified store data and its
// byte enables into an 8-byte window starting at the byte offset.
module store_lane_aligner
    import rv32i_store_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  width_i,
    output logic [63:0] data64_o,
    output logic [7:0]  strb8_o,
    output logic        split_o
);
    logic [3:0] mask;

    // Shift data and mask by the byte offset; any enable above lane 3 needs a second beat.
    always_comb begin
        mask     = base_mask(width_i);
        data64_o = {32'b0, data_i} << {off_i, 3'b000};
        strb8_o  = {4'b0, mask} << off_i;
        split_o  = |strb8_o[7:4];
    end
endmodule

// File: rtl/store_unit_rv32i.sv
// RV32I store unit: converts one SB/SH/SW request into one or two
// word-aligned write beats and reports completion with an error flag.
module store_unit_rv32i
    import rv32i_store_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    store_unit_rv32i_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [7:0]        strb_q, strb_d;
    logic              split_q, split_d;
    logic              err_q, err_d;

    logic [63:0]       al_data64;
    logic [7:0]        al_strb8;
    logic              al_split;
    logic              illegal;

    store_lane_aligner u_aligner (
        .data_i   (bus.req_data),
        .off_i    (bus.req_addr[1:0]),
        .width_i  (bus.req_width_type),
        .data64_o (al_data64),
        .strb8_o  (al_strb8),
        .split_o  (al_split)
    );

    assign illegal = (base_mask(bus.req_width_type) == 4'b0000);

    // State and latched request; reset abandons any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            split_q <= split_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and outputs; beat fields come straight from held
    // registers, so they stay stable while the memory stalls.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        strb_d         = strb_q;
        split_d        = split_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.mem_wvalid = 1'b0;
        bus.mem_waddr  = '0;
        bus.mem_wdata  = '0;
        bus.mem_wstrb  = 4'b0000;
        bus.done_valid = 1'b0;
        bus.done_err   = 1'b0;
        bus.busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    data_d  = al_data64;
                    strb_d  = al_strb8;
                    split_d = al_split;
                    err_d   = illegal || (al_split && !SPLIT_EN);
                    state_d = (illegal || (al_split && !SPLIT_EN)) ? ST_DONE : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                bus.mem_wvalid = 1'b1;
                bus.mem_waddr  = addr_q;
                bus.mem_wdata  = data_q[31:0];
                bus.mem_wstrb  = strb_q[3:0];
                if (bus.mem_wready) begin
                    state_d = split_q ? ST_BEAT1 : ST_DONE;
                end
            end
            ST_BEAT1: begin
                bus.mem_wvalid = 1'b1;
                bus.mem_waddr  = addr_q + ADDR_W'(4);
                bus.mem_wdata  = data_q[63:32];
                bus.mem_wstrb  = strb_q[7:4];
                if (bus.mem_wready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done_valid = 1'b1;
                bus.done_err   = err_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_unit_rv32i.sv
// Directed bench for store_unit_rv32i: one DUT with splitting enabled and one
// with it disabled, sharing clock and reset.
module tb_store_unit_rv32i;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    store_unit_rv32i_if #(.ADDR_W(32)) ifa ();
    store_unit_rv32i_if #(.ADDR_W(32)) ifb ();

    store_unit_rv32i #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    store_unit_rv32i #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the sampling point just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (ifa.req_ready !== 1'b1 || ifa.mem_wvalid !== 1'b0 || ifa.mem_waddr !== 32'h0 ||
            ifa.mem_wdata !== 32'h0 || ifa.mem_wstrb !== 4'h0 || ifa.done_valid !== 1'b0 ||
            ifa.done_err !== 1'b0 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: ready=%b wv=%b addr=%h data=%h strb=%b dv=%b de=%b busy=%b required 1 0 0 0 0 0 0 0",
                     ifa.req_ready, ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wdata, ifa.mem_wstrb,
                     ifa.done_valid, ifa.done_err, ifa.busy);
        end
        checks++;
        if (ifb.req_ready !== 1'b1 || ifb.mem_wvalid !== 1'b0 || ifb.busy !== 1'b0 ||
            ifb.done_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: ready=%b wv=%b busy=%b dv=%b required 1 0 0 0",
                     ifb.req_ready, ifb.mem_wvalid, ifb.busy, ifb.done_valid);
        end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_sb();
        ifa.mem_wready = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd0;
        ifa.req_addr = 32'h0000_1001; ifa.req_data = 32'hDEAD_BEA5;
        tick();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h1000 || ifa.mem_wstrb !== 4'b0010 ||
            ifa.mem_wdata[15:8] !== 8'hA5 || ifa.req_ready !== 1'b0 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL sb_beat: wv=%b addr=%h strb=%b byte1=%h ready=%b busy=%b required 1 00001000 0010 a5 0 1",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[15:8], ifa.req_ready, ifa.busy);
        end
        tick();
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b0 || ifa.mem_wvalid !== 1'b0 || ifa.mem_wstrb !== 4'b0) begin
            errors++;
            $display("FAIL sb_done: dv=%b de=%b wv=%b strb=%b required 1 0 0 0000",
                     ifa.done_valid, ifa.done_err, ifa.mem_wvalid, ifa.mem_wstrb);
        end
        tick();
        checks++;
        if (ifa.done_valid !== 1'b0 || ifa.busy !== 1'b0 || ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_idle: dv=%b busy=%b ready=%b required 0 0 1", ifa.done_valid, ifa.busy, ifa.req_ready);
        end
        $display("sb addr=00001001: one beat, done at T+2");
    endtask

    task automatic test_sh();
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd1;
        ifa.req_addr = 32'h0000_2002; ifa.req_data = 32'h0000_BEEF;
        tick();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h2000 || ifa.mem_wstrb !== 4'b1100 ||
            ifa.mem_wdata[31:16] !== 16'hBEEF) begin
            errors++;
            $display("FAIL sh_beat: wv=%b addr=%h strb=%b hi=%h required 1 00002000 1100 beef",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[31:16]);
        end
        tick();
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b0) begin
            errors++;
            $display("FAIL sh_done: dv=%b de=%b required 1 0", ifa.done_valid, ifa.done_err);
        end
        tick();
        $display("sh addr=00002002: one beat");
    endtask

    task automatic test_split();
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd2;
        ifa.req_addr = 32'h0000_3003; ifa.req_data = 32'h1122_3344;
        tick();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h3000 || ifa.mem_wstrb !== 4'b1000 ||
            ifa.mem_wdata[31:24] !== 8'h44) begin
            errors++;
            $display("FAIL split_beat0: wv=%b addr=%h strb=%b b3=%h required 1 00003000 1000 44",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[31:24]);
        end
        tick();
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h3004 || ifa.mem_wstrb !== 4'b0111 ||
            ifa.mem_wdata[23:0] !== 24'h112233 || ifa.done_valid !== 1'b0) begin
            errors++;
            $display("FAIL split_beat1: wv=%b addr=%h strb=%b lo=%h dv=%b required 1 00003004 0111 112233 0",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[23:0], ifa.done_valid);
        end
        tick();
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b0 || ifa.mem_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL split_done: dv=%b de=%b wv=%b required 1 0 0", ifa.done_valid, ifa.done_err, ifa.mem_wvalid);
        end
        tick();
        $display("sw addr=00003003: two beats, done at T+3");
    endtask

    task automatic test_errors();
        ifb.mem_wready = 1'b1;
        ifb.req_valid = 1'b1; ifb.req_width_type = 3'd2;
        ifb.req_addr = 32'h0000_3003; ifb.req_data = 32'h1122_3344;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd5;
        ifa.req_addr = 32'h0000_4000; ifa.req_data = 32'h5555_AAAA;
        tick();
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        checks++;
        if (ifb.mem_wvalid !== 1'b0 || ifb.done_valid !== 1'b1 || ifb.done_err !== 1'b1) begin
            errors++;
            $display("FAIL nosplit_err: wv=%b dv=%b de=%b required 0 1 1", ifb.mem_wvalid, ifb.done_valid, ifb.done_err);
        end
        checks++;
        if (ifa.mem_wvalid !== 1'b0 || ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_width: wv=%b dv=%b de=%b required 0 1 1", ifa.mem_wvalid, ifa.done_valid, ifa.done_err);
        end
        tick();
        checks++;
        if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0 || ifa.mem_wvalid !== 1'b0 || ifb.mem_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: busy_a=%b busy_b=%b wv_a=%b wv_b=%b required 0 0 0 0",
                     ifa.busy, ifb.busy, ifa.mem_wvalid, ifb.mem_wvalid);
        end
        $display("errors: disallowed split and width 5 complete at T+1 with err");
    endtask

    task automatic test_stall();
        ifa.mem_wready = 1'b0;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd2;
        ifa.req_addr = 32'h0000_1000; ifa.req_data = 32'hCAFE_F00D;
        tick();
        ifa.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h1000 || ifa.mem_wstrb !== 4'b1111 ||
                ifa.mem_wdata !== 32'hCAFE_F00D || ifa.req_ready !== 1'b0 || ifa.done_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: wv=%b addr=%h strb=%b data=%h ready=%b dv=%b required 1 00001000 1111 cafef00d 0 0",
                         i, ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata, ifa.req_ready, ifa.done_valid);
            end
            if (i == 3) ifa.mem_wready = 1'b1;
            tick();
        end
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b0 || ifa.req_ready !== 1'b0 || ifa.mem_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: dv=%b de=%b ready=%b wv=%b required 1 0 0 0",
                     ifa.done_valid, ifa.done_err, ifa.req_ready, ifa.mem_wvalid);
        end
        tick();
        $display("sw addr=00001000: held 4 cycles under stall");
    endtask

    task automatic test_wrap();
        ifa.mem_wready = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd1;
        ifa.req_addr = 32'hFFFF_FFFF; ifa.req_data = 32'h0000_ABCD;
        tick();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.mem_waddr !== 32'hFFFF_FFFC || ifa.mem_wstrb !== 4'b1000 || ifa.mem_wdata[31:24] !== 8'hCD) begin
            errors++;
            $display("FAIL wrap_beat0: addr=%h strb=%b b3=%h required fffffffc 1000 cd",
                     ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[31:24]);
        end
        tick();
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h0 || ifa.mem_wstrb !== 4'b0001 || ifa.mem_wdata[7:0] !== 8'hAB) begin
            errors++;
            $display("FAIL wrap_beat1: wv=%b addr=%h strb=%b b0=%h required 1 00000000 0001 ab",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[7:0]);
        end
        tick();
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: dv=%b de=%b required 1 0", ifa.done_valid, ifa.done_err);
        end
        tick();
        $display("sh addr=ffffffff: beat1 wraps to 00000000");
    endtask

    task automatic test_back_to_back();
        ifa.mem_wready = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd0;
        ifa.req_addr = 32'h0000_5000; ifa.req_data = 32'h0000_0011;
        tick();
        tick();
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done1: dv=%b ready=%b required 1 0", ifa.done_valid, ifa.req_ready);
        end
        tick();
        checks++;
        if (ifa.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b required 1", ifa.req_ready);
        end
        ifa.req_addr = 32'h0000_5003; ifa.req_data = 32'h0000_0022;
        tick();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h5000 || ifa.mem_wstrb !== 4'b1000 || ifa.mem_wdata[31:24] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_beat2: wv=%b addr=%h strb=%b b3=%h required 1 00005000 1000 22",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[31:24]);
        end
        tick();
        tick();
        $display("back-to-back: second accept in cycle after done");
    endtask

    task automatic test_reset_mid();
        ifa.mem_wready = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd2;
        ifa.req_addr = 32'h0000_6002; ifa.req_data = 32'h8765_4321;
        tick();
        ifa.req_valid = 1'b0;
        tick();
        ifa.mem_wready = 1'b0;
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h6004 || ifa.mem_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL mid_beat1: wv=%b addr=%h strb=%b required 1 00006004 0011",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.req_ready !== 1'b1 || ifa.mem_wvalid !== 1'b0 || ifa.mem_waddr !== 32'h0 ||
            ifa.mem_wdata !== 32'h0 || ifa.mem_wstrb !== 4'h0 || ifa.done_valid !== 1'b0 ||
            ifa.done_err !== 1'b0 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b wv=%b addr=%h data=%h strb=%b dv=%b de=%b busy=%b required 1 0 0 0 0 0 0 0",
                     ifa.req_ready, ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wdata, ifa.mem_wstrb,
                     ifa.done_valid, ifa.done_err, ifa.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ifa.mem_wready = 1'b1;
        ifa.req_valid = 1'b1; ifa.req_width_type = 3'd0;
        ifa.req_addr = 32'h0000_7002; ifa.req_data = 32'h0000_0099;
        tick();
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.mem_wvalid !== 1'b1 || ifa.mem_waddr !== 32'h7000 || ifa.mem_wstrb !== 4'b0100 || ifa.mem_wdata[23:16] !== 8'h99) begin
            errors++;
            $display("FAIL post_reset_beat: wv=%b addr=%h strb=%b b2=%h required 1 00007000 0100 99",
                     ifa.mem_wvalid, ifa.mem_waddr, ifa.mem_wstrb, ifa.mem_wdata[23:16]);
        end
        tick();
        checks++;
        if (ifa.done_valid !== 1'b1 || ifa.done_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done: dv=%b de=%b required 1 0", ifa.done_valid, ifa.done_err);
        end
        tick();
        $display("reset during stalled beat1: abandoned, next store accepted");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ifa.req_valid = 1'b0; ifa.req_width_type = 3'd0; ifa.req_addr = '0; ifa.req_data = '0; ifa.mem_wready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_width_type = 3'd0; ifb.req_addr = '0; ifb.req_data = '0; ifb.mem_wready = 1'b0;
        tick();
        tick();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_sb();
        test_sh();
        test_split();
        test_errors();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
